mcif_req_mux4: RTL and testbench

// - Request front-end for the 4-port round-robin arbiter (the mcif_rr_arb4 arbiter).
// - Collects 4 client memory requests and presents them to the arbiter as arb_req.
// - Consumes the one-hot arb_gnt and loads the granted command into a 1-entry output register towards memory.
// - Records the client ID of every issued read in an in-order FIFO, so read beats are routed back to their owner.

---
 rtl/mcif_req_mux4.sv | 108 ++++++++++
 tb/tb_mcif_req_mux4.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mcif_req_mux4.sv
// Request front-end for the 4-port round-robin arbiter: builds arb_req, loads the
// granted client command into a 1-entry output register, and tracks read owners in order.
module mcif_req_mux4 #(
  parameter int AW       = 32,
  parameter int LW       = 8,
  parameter int ID_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      cli_req_valid,
  output logic [3:0]      cli_req_ready,
  input  logic [4*AW-1:0] cli_req_addr,
  input  logic [4*LW-1:0] cli_req_len,
  input  logic [3:0]      cli_req_wr,
  output logic [3:0]      arb_req,
  input  logic [3:0]      arb_gnt,
  output logic            gnt_valid,
  output logic            gnt_ready,
  output logic            mem_cmd_valid,
  input  logic            mem_cmd_ready,
  output logic [AW-1:0]   mem_cmd_addr,
  output logic [LW-1:0]   mem_cmd_len,
  output logic            mem_cmd_wr,
  output logic [1:0]      mem_cmd_id,
  input  logic            mem_rd_valid,
  input  logic            mem_rd_last,
  output logic [1:0]      rd_owner,
  output logic            rd_owner_valid,
  output logic            err
);
  localparam int PW = $clog2(ID_DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] count;
  logic [PW-1:0] wptr, rptr;
  logic [1:0]    id_mem [ID_DEPTH];

  logic       pop, push, room, slot, ld, multi;
  logic [1:0] g;
  logic [3:0] gnt_lo;

  assign rd_owner_valid = (count != '0);
  assign rd_owner       = rd_owner_valid ? id_mem[rptr] : 2'd0;

  assign pop  = mem_rd_valid & mem_rd_last & rd_owner_valid;
  assign room = (count < CW'(ID_DEPTH)) | pop;
  assign slot = ~mem_cmd_valid | mem_cmd_ready;

  // Illegal multi-hot grants collapse onto the lowest set index.
  assign gnt_lo = arb_gnt & (~arb_gnt + 4'd1);
  assign multi  = |(arb_gnt & (arb_gnt - 4'd1));

  always_comb begin
    g = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (arb_gnt[i]) g = 2'(i);
  end

  assign gnt_valid = |arb_gnt;
  assign ld        = gnt_valid & slot;
  assign gnt_ready = ld;
  assign push      = ld & ~cli_req_wr[g];

  for (genvar i = 0; i < 4; i++) begin : g_cli
    // Writes bypass the owner FIFO, so only reads are held back when it is full.
    assign arb_req[i]       = cli_req_valid[i] & (cli_req_wr[i] | room);
    assign cli_req_ready[i] = gnt_lo[i] & slot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cmd_valid <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_cmd_len   <= '0;
      mem_cmd_wr    <= 1'b0;
      mem_cmd_id    <= 2'd0;
    end else if (ld) begin
      mem_cmd_valid <= 1'b1;
      mem_cmd_addr  <= cli_req_addr[g*AW +: AW];
      mem_cmd_len   <= cli_req_len[g*LW +: LW];
      mem_cmd_wr    <= cli_req_wr[g];
      mem_cmd_id    <= g;
    end else if (mem_cmd_ready) begin
      mem_cmd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
      for (int i = 0; i < ID_DEPTH; i++) id_mem[i] <= 2'd0;
    end else begin
      if (push) begin
        id_mem[wptr] <= g;
        wptr         <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= err | multi | (mem_rd_valid & ~rd_owner_valid);
  end
endmodule

// File: tb/tb_mcif_req_mux4.sv
// Directed bench for mcif_req_mux4 with a behavioural round-robin arbiter in the loop.
module tb_mcif_req_mux4;
  localparam int AW = 32;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      cli_req_valid, cli_req_ready, cli_req_wr;
  logic [4*AW-1:0] cli_req_addr;
  logic [4*LW-1:0] cli_req_len;
  logic [3:0]      arb_req, arb_gnt, rr_gnt, ovr_gnt;
  logic            ovr_en;
  logic            gnt_valid, gnt_ready;
  logic            mem_cmd_valid, mem_cmd_ready, mem_cmd_wr;
  logic [AW-1:0]   mem_cmd_addr;
  logic [LW-1:0]   mem_cmd_len;
  logic [1:0]      mem_cmd_id, rd_owner, ptr;
  logic            mem_rd_valid, mem_rd_last, rd_owner_valid, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mcif_req_mux4 #(.AW(AW), .LW(LW), .ID_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .cli_req_valid(cli_req_valid), .cli_req_ready(cli_req_ready),
    .cli_req_addr(cli_req_addr), .cli_req_len(cli_req_len), .cli_req_wr(cli_req_wr),
    .arb_req(arb_req), .arb_gnt(arb_gnt),
    .gnt_valid(gnt_valid), .gnt_ready(gnt_ready),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
    .mem_cmd_wr(mem_cmd_wr), .mem_cmd_id(mem_cmd_id),
    .mem_rd_valid(mem_rd_valid), .mem_rd_last(mem_rd_last),
    .rd_owner(rd_owner), .rd_owner_valid(rd_owner_valid), .err(err)
  );

  // Round-robin arbiter: search starts at ptr, ptr moves past the winner on consume.
  always_comb begin
    rr_gnt = 4'b0000;
    for (int k = 0; k < 4; k++)
      if (rr_gnt == 4'b0000 && arb_req[(32'(ptr) + k) % 4]) rr_gnt[(32'(ptr) + k) % 4] = 1'b1;
  end
  assign arb_gnt = ovr_en ? ovr_gnt : rr_gnt;

  always @(posedge clk or posedge rst) begin
    if (rst) ptr <= 2'd0;
    else if (gnt_ready) begin
      for (int k = 3; k >= 0; k--)
        if (arb_gnt[k]) ptr <= 2'(k + 1);
    end
  end

  task automatic set_cli(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic w);
    cli_req_addr[i*AW +: AW] = a;
    cli_req_len[i*LW +: LW]  = l;
    cli_req_wr[i]            = w;
    cli_req_valid[i]         = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++; if (mem_cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", mem_cmd_valid); end
    total++; if (rd_owner_valid !== 1'b0 || rd_owner !== 2'd0) begin bad++; $display("FAIL reset_fifo got=%b/%0d exp=0/0", rd_owner_valid, rd_owner); end
    total++; if (err !== 1'b0 || mem_cmd_addr !== '0 || mem_cmd_id !== 2'd0) begin bad++; $display("FAIL reset_regs err=%b addr=%h id=%0d exp=0", err, mem_cmd_addr, mem_cmd_id); end
    @(negedge clk) rst = 1'b0;
    mem_cmd_ready = 1'b1;
    for (int i = 0; i < 3; i++) set_cli(i, AW'(32'h40 * i), 8'd1, 1'b0);
    repeat (3) @(negedge clk);
    cli_req_valid = 4'b0000;
    #1;
    total++; if (rd_owner_valid !== 1'b1 || rd_owner !== 2'd0 || mem_cmd_valid !== 1'b1) begin bad++; $display("FAIL queued_reads ov=%b own=%0d cv=%b exp=1/0/1", rd_owner_valid, rd_owner, mem_cmd_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (mem_cmd_valid !== 1'b0 || rd_owner_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL midburst_reset cv=%b ov=%b err=%b exp=0/0/0", mem_cmd_valid, rd_owner_valid, err); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_single_read();
    set_cli(2, 32'h100, 8'd3, 1'b0);
    #1;
    total++; if (cli_req_ready !== 4'b0100) begin bad++; $display("FAIL rd_handshake got=%b exp=0100", cli_req_ready); end
    @(negedge clk);
    cli_req_valid = 4'b0000;
    total++; if (mem_cmd_valid !== 1'b1 || mem_cmd_id !== 2'd2 || mem_cmd_wr !== 1'b0 || mem_cmd_addr !== 32'h100 || mem_cmd_len !== 8'd3)
      begin bad++; $display("FAIL rd_cmd v=%b id=%0d wr=%b addr=%h len=%0d exp=1/2/0/100/3", mem_cmd_valid, mem_cmd_id, mem_cmd_wr, mem_cmd_addr, mem_cmd_len); end
    for (int b = 0; b < 4; b++) begin
      mem_rd_valid = 1'b1;
      mem_rd_last  = (b == 3);
      #1;
      total++; if (rd_owner_valid !== 1'b1 || rd_owner !== 2'd2) begin bad++; $display("FAIL rd_beat%0d ov=%b own=%0d exp=1/2", b, rd_owner_valid, rd_owner); end
      @(negedge clk);
    end
    mem_rd_valid = 1'b0;
    mem_rd_last  = 1'b0;
    total++; if (rd_owner_valid !== 1'b0 || mem_cmd_valid !== 1'b0) begin bad++; $display("FAIL rd_drained ov=%b cv=%b exp=0/0", rd_owner_valid, mem_cmd_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] order [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    for (int i = 0; i < 4; i++) set_cli(i, AW'(32'h1000 + 16 * i), LW'(i), 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (cli_req_ready !== (4'b0001 << order[k])) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=%b", k, cli_req_ready, 4'b0001 << order[k]); end
      @(negedge clk);
      total++; if (mem_cmd_valid !== 1'b1 || mem_cmd_id !== order[k] || mem_cmd_addr !== AW'(32'h1000 + 16 * order[k]))
        begin bad++; $display("FAIL b2b_cmd%0d v=%b id=%0d addr=%h exp=1/%0d", k, mem_cmd_valid, mem_cmd_id, mem_cmd_addr, order[k]); end
      cli_req_valid[order[k]] = 1'b0;
    end
    @(negedge clk);
    total++; if (mem_cmd_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", mem_cmd_valid); end
  endtask

  task automatic test_stall();
    set_cli(0, 32'hA0, 8'd0, 1'b1);
    #1;
    total++; if (cli_req_ready !== 4'b0001) begin bad++; $display("FAIL stall_setup got=%b exp=0001", cli_req_ready); end
    @(negedge clk);
    cli_req_valid = 4'b0000;
    mem_cmd_ready = 1'b0;
    set_cli(1, 32'h110, 8'd1, 1'b1);
    set_cli(3, 32'h330, 8'd3, 1'b1);
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (mem_cmd_valid !== 1'b1 || mem_cmd_id !== 2'd0 || mem_cmd_addr !== 32'hA0 || gnt_valid !== 1'b1 || gnt_ready !== 1'b0 || cli_req_ready !== 4'b0000)
        begin bad++; $display("FAIL stall_c%0d v=%b id=%0d addr=%h gv=%b gr=%b rdy=%b exp=1/0/a0/1/0/0000", c, mem_cmd_valid, mem_cmd_id, mem_cmd_addr, gnt_valid, gnt_ready, cli_req_ready); end
      @(negedge clk);
    end
    mem_cmd_ready = 1'b1;
    #1;
    total++; if (cli_req_ready !== 4'b0010 || gnt_ready !== 1'b1) begin bad++; $display("FAIL stall_release rdy=%b gr=%b exp=0010/1", cli_req_ready, gnt_ready); end
    @(negedge clk);
    total++; if (mem_cmd_id !== 2'd1 || mem_cmd_addr !== 32'h110) begin bad++; $display("FAIL stall_next1 id=%0d addr=%h exp=1/110", mem_cmd_id, mem_cmd_addr); end
    cli_req_valid[1] = 1'b0;
    @(negedge clk);
    total++; if (mem_cmd_id !== 2'd3 || mem_cmd_addr !== 32'h330) begin bad++; $display("FAIL stall_next3 id=%0d addr=%h exp=3/330", mem_cmd_id, mem_cmd_addr); end
    cli_req_valid[3] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fifo_full();
    set_cli(1, 32'h200, 8'd0, 1'b0);
    repeat (8) @(negedge clk);
    #1;
    total++; if (arb_req !== 4'b0000 || rd_owner_valid !== 1'b1 || rd_owner !== 2'd1) begin bad++; $display("FAIL full_mask req=%b ov=%b own=%0d exp=0000/1/1", arb_req, rd_owner_valid, rd_owner); end
    set_cli(0, 32'h300, 8'd0, 1'b1);
    #1;
    total++; if (arb_req !== 4'b0001 || cli_req_ready !== 4'b0001) begin bad++; $display("FAIL full_write req=%b rdy=%b exp=0001/0001", arb_req, cli_req_ready); end
    @(negedge clk);
    total++; if (mem_cmd_wr !== 1'b1 || mem_cmd_id !== 2'd0) begin bad++; $display("FAIL full_wcmd wr=%b id=%0d exp=1/0", mem_cmd_wr, mem_cmd_id); end
    cli_req_valid[0] = 1'b0;
    mem_rd_valid = 1'b1;
    mem_rd_last  = 1'b1;
    #1;
    total++; if (arb_req !== 4'b0010 || cli_req_ready !== 4'b0010) begin bad++; $display("FAIL full_pushpop req=%b rdy=%b exp=0010/0010", arb_req, cli_req_ready); end
    @(negedge clk);
    mem_rd_valid = 1'b0;
    mem_rd_last  = 1'b0;
    #1;
    total++; if (mem_cmd_id !== 2'd1 || mem_cmd_wr !== 1'b0 || arb_req !== 4'b0000) begin bad++; $display("FAIL full_after id=%0d wr=%b req=%b exp=1/0/0000", mem_cmd_id, mem_cmd_wr, arb_req); end
    cli_req_valid[1] = 1'b0;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      mem_rd_valid = 1'b1;
      mem_rd_last  = 1'b1;
      #1;
      total++; if (rd_owner_valid !== 1'b1 || rd_owner !== 2'd1) begin bad++; $display("FAIL drain%0d ov=%b own=%0d exp=1/1", b, rd_owner_valid, rd_owner); end
    end
    @(negedge clk);
    mem_rd_valid = 1'b0;
    mem_rd_last  = 1'b0;
    total++; if (rd_owner_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL drain_end ov=%b err=%b exp=0/0", rd_owner_valid, err); end
  endtask

  task automatic test_err_empty();
    mem_rd_valid = 1'b1;
    mem_rd_last  = 1'b1;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    mem_rd_last  = 1'b0;
    total++; if (err !== 1'b1 || rd_owner_valid !== 1'b0) begin bad++; $display("FAIL err_set err=%b ov=%b exp=1/0", err, rd_owner_valid); end
    repeat (3) @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_multi_gnt();
    rst = 1'b1;
    #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
    @(negedge clk) rst = 1'b0;
    set_cli(1, 32'h111, 8'd1, 1'b1);
    set_cli(2, 32'h222, 8'd2, 1'b1);
    ovr_gnt = 4'b0110;
    ovr_en  = 1'b1;
    #1;
    total++; if (cli_req_ready !== 4'b0010 || gnt_valid !== 1'b1) begin bad++; $display("FAIL multi_ready rdy=%b gv=%b exp=0010/1", cli_req_ready, gnt_valid); end
    @(negedge clk);
    cli_req_valid = 4'b0000;
    ovr_en = 1'b0;
    total++; if (mem_cmd_id !== 2'd1 || mem_cmd_addr !== 32'h111 || err !== 1'b1) begin bad++; $display("FAIL multi_cmd id=%0d addr=%h err=%b exp=1/111/1", mem_cmd_id, mem_cmd_addr, err); end
  endtask

  initial begin
    cli_req_valid = '0; cli_req_wr = '0; cli_req_addr = '0; cli_req_len = '0;
    mem_cmd_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_last = 1'b0;
    ovr_en = 1'b0; ovr_gnt = 4'b0000;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_stall();
    test_fifo_full();
    test_err_empty();
    test_multi_gnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
